playback_state_handler: RTL

Replays a recording held in the note RAM by reading 33-bit note records in address order and re-creating the 29-key pressed-key vector in real time against a local microsecond timer. It sits beside the record state handler, on the read port of the shared NoteStorage RAM. Its key vector feeds the same audio and keyboard-display paths as live input. Start and stop come from the top-level state machine.

---
 rtl/playback_state_handler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/playback_state_handler.sv
// Replays note records from the NoteStorage read port, toggling bits of the
// 29-key vector once the local microsecond timer reaches each record's timestamp.
module playback_state_handler #(
  parameter int CLOCKS_PER_US = 50,
  parameter int READ_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  recordLength,
  input  logic [32:0] retrievedNoteData,
  output logic [6:0]  noteReadAddress,
  output logic [28:0] outputKeyState,
  output logic        playing,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet
  // FETCH | address held for READ_LATENCY cycles, then record latched
  // WAIT  | waiting for timer to reach the record timestamp
  // APPLY | toggle key bit, advance address
  // DONE  | one cycle before the done pulse and return to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_APPLY,
    S_DONE
  } state_t;

  localparam int PW = (CLOCKS_PER_US > 1) ? $clog2(CLOCKS_PER_US) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLOCKS_PER_US - 1);
  localparam logic [LW-1:0] FETCH_MAX    = LW'(READ_LATENCY - 1);
  localparam logic [4:0]    KEY_END      = 5'd31;
  localparam logic [4:0]    KEY_COUNT    = 5'd29;

  state_t        state_q;
  logic [6:0]    addr_q;
  logic [28:0]   key_q;
  logic          playing_q;
  logic          done_q;
  logic [32:0]   record_q;
  logic [27:0]   timer_q;
  logic [PW-1:0] prescale_q;
  logic [LW-1:0] fetch_cnt_q;
  logic [7:0]    addr_inc_d;

  // Address compare is done on 8 bits so that 127 -> 128 can match recordLength.
  always_comb begin
    addr_inc_d = {1'b0, addr_q} + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      key_q       <= '0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
      record_q    <= '0;
      timer_q     <= '0;
      prescale_q  <= '0;
      fetch_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (state_q != S_IDLE) begin
        if (prescale_q == PRESCALE_MAX) begin
          prescale_q <= '0;
          if (timer_q != '1) begin
            timer_q <= timer_q + 28'd1;
          end
        end else begin
          prescale_q <= prescale_q + PW'(1);
        end
      end

      if (stop && (state_q != S_IDLE)) begin
        state_q   <= S_IDLE;
        key_q     <= '0;
        playing_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !stop) begin
              key_q       <= '0;
              timer_q     <= '0;
              prescale_q  <= '0;
              addr_q      <= '0;
              fetch_cnt_q <= '0;
              playing_q   <= 1'b1;
              state_q     <= (recordLength == 8'd0) ? S_DONE : S_FETCH;
            end
          end

          S_FETCH: begin
            if (fetch_cnt_q == FETCH_MAX) begin
              fetch_cnt_q <= '0;
              record_q    <= retrievedNoteData;
              state_q     <= (retrievedNoteData[32:28] == KEY_END) ? S_DONE : S_WAIT;
            end else begin
              fetch_cnt_q <= fetch_cnt_q + LW'(1);
            end
          end

          S_WAIT: begin
            if (timer_q >= record_q[27:0]) begin
              state_q <= S_APPLY;
            end
          end

          S_APPLY: begin
            // Indices 29 and 30 consume their time slot but change no key.
            if (record_q[32:28] < KEY_COUNT) begin
              key_q <= key_q ^ (29'd1 << record_q[32:28]);
            end
            addr_q <= addr_inc_d[6:0];
            state_q <= (addr_inc_d == recordLength) ? S_DONE : S_FETCH;
          end

          S_DONE: begin
            done_q    <= 1'b1;
            playing_q <= 1'b0;
            key_q     <= '0;
            state_q   <= S_IDLE;
          end

          default: begin
            state_q   <= S_IDLE;
            key_q     <= '0;
            playing_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign noteReadAddress = addr_q;
  assign outputKeyState  = key_q;
  assign playing         = playing_q;
  assign done            = done_q;

endmodule
